// File: rtl/weight_mask_index_decoder.sv
// rtl/weight_mask_index_decoder.sv - sparse weight mask to per-byte set-bit index stream decoder
module weight_mask_index_decoder #(
    parameter int Mask_Width = 64,
    parameter int Cnt_Width  = 16,
    localparam int Grp       = Mask_Width / 8,
    localparam int Idx_Width = Grp * 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [Cnt_Width-1:0]  k_k_channels,
    input  logic [Mask_Width-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [Idx_Width-1:0]  m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [Grp-1:0]        m_terr,
    output logic                  busy,
    output logic                  done,
    output logic                  err_sticky
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [Cnt_Width-1:0] CntOne = {{(Cnt_Width-1){1'b0}}, 1'b1};

    state_t                 state_q;
    state_t                 state_d;
    logic [Cnt_Width-1:0]   count_q;
    logic [Cnt_Width-1:0]   acc_q;
    logic [Cnt_Width-1:0]   acc_nxt;
    logic                   start_ok;
    logic                   s_hs;
    logic                   m_hs;
    logic [Idx_Width-1:0]   dec_data;
    logic [Grp-1:0]         dec_err;

    // Returns {err, slot3, slot2, slot1, slot0}; only the four lowest set bits are kept.
    function automatic logic [12:0] decode_byte(input logic [7:0] b);
        logic [11:0] slots;
        int          n;
        slots = '0;
        n     = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                if (n < 4) slots[3*n +: 3] = 3'(i);
                n = n + 1;
            end
        end
        return {(n != 4), slots};
    endfunction

    always_comb begin
        dec_data = '0;
        dec_err  = '0;
        for (int g = 0; g < Grp; g++) begin
            {dec_err[g], dec_data[12*g +: 12]} = decode_byte(s_tdata[8*g +: 8]);
        end
    end

    assign start_ok = (state_q == IDLE) && start;
    assign s_tready = (state_q == RUN) && (acc_q < count_q) && (!m_tvalid || m_tready);
    assign s_hs     = s_tvalid && s_tready;
    assign m_hs     = m_tvalid && m_tready;
    assign acc_nxt  = acc_q + CntOne;
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = (k_k_channels != '0) ? RUN : DONE;
            end
            RUN: begin
                if (m_hs && m_tlast) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The output register doubles as the one-deep skid: a new word only enters when it is free or draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            acc_q      <= '0;
            m_tdata    <= '0;
            m_terr     <= '0;
            m_tvalid   <= 1'b0;
            m_tlast    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            if (start_ok) begin
                count_q <= k_k_channels;
                acc_q   <= '0;
            end
            if (s_hs) begin
                m_tdata  <= dec_data;
                m_terr   <= dec_err;
                m_tlast  <= (acc_nxt == count_q);
                m_tvalid <= 1'b1;
                acc_q    <= acc_nxt;
            end else if (m_hs) begin
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
            end
            if (start_ok) begin
                err_sticky <= 1'b0;
            end else if (m_hs && (|m_terr)) begin
                err_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_weight_mask_index_decoder.sv
// tb/tb_weight_mask_index_decoder.sv - directed self-checking bench for weight_mask_index_decoder
module tb_weight_mask_index_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] k_k_channels;
    logic [63:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [95:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [7:0]  m_terr;
    logic        busy;
    logic        done;
    logic        err_sticky;

    int n_cmp = 0;
    int n_err = 0;

    logic [95:0] exp_fac;
    logic [95:0] exp_688;
    logic [95:0] exp_s3;
    logic [63:0] in_w  [4];
    logic [95:0] exp_w [4];
    int          in_idx;
    int          out_idx;
    logic        in_hs;
    logic        out_hs;
    logic        saw_done;

    weight_mask_index_decoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .k_k_channels (k_k_channels),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .m_terr       (m_terr),
        .busy         (busy),
        .done         (done),
        .err_sticky   (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_fac  = {8{12'hFAC}};
        exp_688  = {8{12'h688}};
        exp_s3   = {{7{12'h688}}, 12'h088};
        in_w[0]  = {8{8'h0F}};  exp_w[0] = {8{12'h688}};
        in_w[1]  = {8{8'hF0}};  exp_w[1] = {8{12'hFAC}};
        in_w[2]  = {8{8'h33}};  exp_w[2] = {8{12'hB08}};
        in_w[3]  = {8{8'hCC}};  exp_w[3] = {8{12'hF9A}};

        rst_n = 1'b0; start = 1'b0; k_k_channels = '0;
        s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b1;

        // reset state
        @(negedge clk); @(negedge clk); #1;
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_sticky", err_sticky, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_terr", m_terr, 0);
        rst_n = 1'b1;

        // scenario 1: three 0xF0 words back to back
        @(negedge clk);
        start = 1'b1; k_k_channels = 16'd3; s_tvalid = 1'b1; s_tdata = {8{8'hF0}}; m_tready = 1'b1;
        #1 chk("s1_idle_no_ready", s_tready, 0);
        @(negedge clk); start = 1'b0;
        #1 chk("s1_busy", busy, 1);
        chk("s1_s_tready", s_tready, 1);
        chk("s1_no_out_yet", m_tvalid, 0);
        @(negedge clk); #1;
        chk("s1_w1_valid", m_tvalid, 1);
        chk("s1_w1_data", m_tdata, exp_fac);
        chk("s1_w1_last", m_tlast, 0);
        chk("s1_w1_terr", m_terr, 0);
        @(negedge clk); #1;
        chk("s1_w2_valid", m_tvalid, 1);
        chk("s1_w2_last", m_tlast, 0);
        @(negedge clk); s_tvalid = 1'b0; #1;
        chk("s1_w3_valid", m_tvalid, 1);
        chk("s1_w3_data", m_tdata, exp_fac);
        chk("s1_w3_last", m_tlast, 1);
        chk("s1_w3_no_ready", s_tready, 0);
        @(negedge clk); #1;
        chk("s1_done", done, 1);
        chk("s1_valid_clr", m_tvalid, 0);
        chk("s1_busy_clr", busy, 0);
        chk("s1_err_sticky", err_sticky, 0);
        @(negedge clk); #1;
        chk("s1_done_pulse", done, 0);

        // scenario 2: 0x0F word
        @(negedge clk);
        start = 1'b1; k_k_channels = 16'd1; s_tvalid = 1'b1; s_tdata = {8{8'h0F}};
        @(negedge clk); start = 1'b0;
        @(negedge clk); s_tvalid = 1'b0; #1;
        chk("s2_data", m_tdata, exp_688);
        chk("s2_terr", m_terr, 8'h00);
        chk("s2_last", m_tlast, 1);
        @(negedge clk); #1;
        chk("s2_done", done, 1);

        // scenario 3: under- and over-populated bytes
        @(negedge clk);
        start = 1'b1; k_k_channels = 16'd1; s_tvalid = 1'b1; s_tdata = 64'h0F0F_0F0F_0F0F_FF07;
        @(negedge clk); start = 1'b0;
        @(negedge clk); s_tvalid = 1'b0; #1;
        chk("s3_data", m_tdata, exp_s3);
        chk("s3_terr", m_terr, 8'h03);
        chk("s3_last", m_tlast, 1);
        @(negedge clk); #1;
        chk("s3_done", done, 1);
        chk("s3_err_sticky", err_sticky, 1);
        @(negedge clk); #1;
        chk("s3_err_sticky_hold", err_sticky, 1);

        // scenario 4: four words, output back-pressure alternating
        in_idx = 0; out_idx = 0; in_hs = 1'b0; out_hs = 1'b0; saw_done = 1'b0;
        @(negedge clk);
        start = 1'b1; k_k_channels = 16'd4; s_tvalid = 1'b0;
        @(negedge clk); start = 1'b0;
        #1 chk("s4_err_sticky_clr", err_sticky, 0);
        chk("s4_busy", busy, 1);
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (in_hs) in_idx++;
            if (out_hs) out_idx++;
            if (done) begin
                saw_done = 1'b1;
                break;
            end
            s_tvalid = (in_idx < 4);
            s_tdata  = (in_idx < 4) ? in_w[in_idx] : '0;
            m_tready = (cyc % 2 == 0);
            #1;
            if (m_tvalid) begin
                chk("s4_data", m_tdata, (out_idx < 4) ? exp_w[out_idx] : '0);
                chk("s4_last", m_tlast, (out_idx == 3));
                if (!m_tready) chk("s4_stall_no_ready", s_tready, 0);
            end
            in_hs  = s_tvalid && s_tready;
            out_hs = m_tvalid && m_tready;
            @(negedge clk);
        end
        s_tvalid = 1'b0; m_tready = 1'b1;
        chk("s4_saw_done", saw_done, 1);
        chk("s4_in_count", in_idx, 4);
        chk("s4_out_count", out_idx, 4);
        @(negedge clk);

        // scenario 5: empty job, then start ignored while busy
        @(negedge clk);
        start = 1'b1; k_k_channels = 16'd0; s_tvalid = 1'b1; s_tdata = {8{8'h0F}};
        #1 chk("s5_idle_no_ready", s_tready, 0);
        @(negedge clk); start = 1'b0; #1;
        chk("s5_done", done, 1);
        chk("s5_no_ready", s_tready, 0);
        chk("s5_not_busy", busy, 0);
        @(negedge clk); s_tvalid = 1'b0; #1;
        chk("s5_done_pulse", done, 0);
        @(negedge clk);
        start = 1'b1; k_k_channels = 16'd2;
        @(negedge clk);
        start = 1'b1; k_k_channels = 16'd5;
        #1 chk("s5_busy", busy, 1);
        @(negedge clk);
        start = 1'b0; s_tvalid = 1'b1; s_tdata = {8{8'h0F}}; m_tready = 1'b1;
        #1 chk("s5_still_busy", busy, 1);
        chk("s5_no_out", m_tvalid, 0);
        @(negedge clk); #1;
        chk("s5_w1_last", m_tlast, 0);
        @(negedge clk); s_tvalid = 1'b0; #1;
        chk("s5_w2_last", m_tlast, 1);
        chk("s5_w2_data", m_tdata, exp_688);
        @(negedge clk); #1;
        chk("s5_job_done", done, 1);

        // scenario 6: reset mid-job, then a clean two-word job
        @(negedge clk);
        start = 1'b1; k_k_channels = 16'd8; s_tvalid = 1'b1; s_tdata = {8{8'h33}}; m_tready = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("s6_mid_valid", m_tvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_rst_valid", m_tvalid, 0);
        chk("s6_rst_data", m_tdata, 0);
        chk("s6_rst_last", m_tlast, 0);
        chk("s6_rst_ready", s_tready, 0);
        chk("s6_rst_busy", busy, 0);
        chk("s6_rst_done", done, 0);
        chk("s6_rst_terr", m_terr, 0);
        @(negedge clk); #1;
        chk("s6_rst_hold_done", done, 0);
        rst_n = 1'b1; s_tvalid = 1'b0;
        @(negedge clk); #1;
        chk("s6_post_done", done, 0);
        chk("s6_post_busy", busy, 0);
        @(negedge clk);
        start = 1'b1; k_k_channels = 16'd2; s_tvalid = 1'b1; s_tdata = {8{8'hF0}};
        @(negedge clk); start = 1'b0;
        @(negedge clk); #1;
        chk("s6_w1_valid", m_tvalid, 1);
        chk("s6_w1_data", m_tdata, exp_fac);
        chk("s6_w1_last", m_tlast, 0);
        @(negedge clk); s_tvalid = 1'b0; #1;
        chk("s6_w2_last", m_tlast, 1);
        @(negedge clk); #1;
        chk("s6_done", done, 1);
        @(negedge clk); #1;
        chk("s6_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
